// File: rtl/bcd_seg_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seg_scanner: two-digit multiplexed 7-segment driver for a BCD pair.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    SHOW_ONES = 1'b0,
    SHOW_TENS = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             w_wrap;
  logic [3:0]       w_digit;
  logic [6:0]       w_glyph;

  assign w_wrap = (cnt_q == C_CNT_MAX);

  always_comb begin
    cnt_d   = w_wrap ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    if (w_wrap) begin
      state_d = (state_q == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
    end
    tens_d = load ? tens : tens_q;
    ones_d = load ? ones : ones_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= SHOW_ONES;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign w_digit = (state_q == SHOW_TENS) ? tens_q : ones_q;

  always_comb begin
    case (w_digit)
      4'd0:    w_glyph = 7'h3F;
      4'd1:    w_glyph = 7'h06;
      4'd2:    w_glyph = 7'h5B;
      4'd3:    w_glyph = 7'h4F;
      4'd4:    w_glyph = 7'h66;
      4'd5:    w_glyph = 7'h6D;
      4'd6:    w_glyph = 7'h7D;
      4'd7:    w_glyph = 7'h07;
      4'd8:    w_glyph = 7'h7F;
      4'd9:    w_glyph = 7'h6F;
      default: w_glyph = 7'h40;
    endcase
  end

  // A zero tens digit is a leading zero: keep the digit enabled but dark.
  assign seg   = (state_q == SHOW_TENS && tens_q == 4'd0) ? 7'h00 : w_glyph;
  assign an    = (state_q == SHOW_TENS) ? 2'b10 : 2'b01;
  assign frame = (state_q == SHOW_TENS) && w_wrap;

endmodule
`default_nettype wire

// File: doc/bcd_seg_scanner.md
BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4, meaning clock cycles each digit stays selected; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  when high at a rising edge, capture tens and ones.
REQ-005 SHALL have port tens  input  4  BCD tens digit, as produced by the upstream binary-to-BCD stage.
REQ-006 SHALL have port ones  input  4  BCD ones digit, as produced by the upstream binary-to-BCD stage.
REQ-007 SHALL have port seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}, active-high.
REQ-008 SHALL have port an  output  2  digit enable, one-hot, active-high: 2'b01 = ones digit, 2'b10 = tens digit.
REQ-009 SHALL have port frame  output  1  one-cycle pulse marking the end of a full two-digit scan.

Function
REQ-010 SHALL hold digit registers tens_q and ones_q, 4 bits each, loaded from tens and ones on any rising edge with load=1, otherwise unchanged.
REQ-011 SHALL have a two-state scan FSM: SHOW_ONES and SHOW_TENS.
REQ-012 SHALL have a prescaler counter of width clog2(REFRESH_DIV) that counts 0..REFRESH_DIV-1 and wraps to 0.
REQ-013 SHALL change FSM state (SHOW_ONES->SHOW_TENS, SHOW_TENS->SHOW_ONES) on the edge where the counter wraps, and only on that edge; each digit is therefore selected exactly REFRESH_DIV cycles.
REQ-014 SHALL decode an combinationally from FSM state: SHOW_ONES -> 2'b01, SHOW_TENS -> 2'b10; never 2'b00 or 2'b11 outside reset.
REQ-015 SHALL decode seg combinationally from the selected digit register: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-016 SHALL drive seg=7'h40 (dash, g only) for any selected digit value 10..15.
REQ-017 SHALL blank leading zeros: in SHOW_TENS with tens_q=0, seg=7'h00 while an stays 2'b10; the ones digit is never blanked.
REQ-018 SHALL assert frame combinationally when state=SHOW_TENS and counter=REFRESH_DIV-1, i.e. one cycle per 2*REFRESH_DIV cycles.
REQ-019 SHALL make a load visible on seg in the first cycle after the capturing edge; there is no additional latency.
REQ-020 SHALL treat load coinciding with a counter wrap as both events taking effect on the same edge: new digits and new state together.
REQ-021 SHALL NOT let load affect the counter or the FSM state.

Reset
REQ-022 SHALL, while rst=1, asynchronously force: counter=0, state=SHOW_ONES, tens_q=0, ones_q=0.
REQ-023 SHALL therefore present during and after reset: an=2'b01, seg=7'h3F, frame=0.
REQ-024 SHALL, when rst is asserted mid-scan, abandon the scan immediately and restart from counter=0 in SHOW_ONES.
REQ-025 SHALL ignore load while rst=1.
REQ-026 SHALL resume counting on the first rising edge after rst deasserts.

Verification
REQ-027 Bench SHALL use REFRESH_DIV=4 and cover reset: rst=1 -> an=01, seg=3F, frame=0; rst=0 -> an toggles to 10 after exactly 4 edges and back to 01 after 8.
REQ-028 Bench SHALL cover load: tens=2, ones=7, load pulse -> seg=07 in SHOW_ONES and seg=5B in SHOW_TENS.
REQ-029 Bench SHALL cover leading-zero blanking: load tens=0, ones=5 -> seg=6D with an=01, seg=00 with an=10.
REQ-030 Bench SHALL cover invalid BCD: load tens=12, ones=15 -> seg=40 in both states.
REQ-031 Bench SHALL cover frame: frame high exactly one cycle per 8 cycles, coincident with the last SHOW_TENS cycle; load on a wrap edge updates digits and state together.
REQ-032 Bench SHALL cover mid-scan reset: rst pulsed in cycle 2 of SHOW_TENS -> an=01 and seg=3F immediately, with the next toggle 4 edges after release.
